buffer_reader: RTL and testbench
================================

# buffer_reader

Read-side controller for the FIFO/LIFO buffer. It issues `Rden` pulses against the buffer's `Empty` flag and registered `Dataout` port, and captures each returned word into a 2-entry skid buffer. Words go downstream on a valid/ready stream, in bursts of programmable length or as a drain-until-empty. It sits on the buffer's read clock domain, between the buffer and the consuming datapath.

## Interface
- `dat_width`, 32, word width; must match the buffer.
- `BURST_W`, 8, width of the burst length and word counters.

- `Rdclk`  in  1  sole clock; all logic on posedge.
- `Rst`  in  1  asynchronous, active-low reset.
- `Empty`  in  1  buffer empty flag (registered, lags buffer state by up to 2 cycles).
- `Dataout`  in  dat_width  buffer read data; valid only in the cycle after a cycle with `Rden`=1, zero otherwise.
- `Rden`  out  1  read strobe to the buffer.
- `Start`  in  1  single-cycle burst request; sampled only in IDLE.
- `Burst_len`  in  BURST_W  words to read; sampled with `Start`; 0 = drain mode.
- `Out_data`  out  dat_width  stream data (head of skid buffer).
- `Out_valid`  out  1  stream valid.
- `Out_ready`  in  1  stream ready.
- `Busy`  out  1  high in any state other than IDLE.
- `Done`  out  1  one-cycle pulse at end of burst.
- `Word_cnt`  out  BURST_W  words transferred downstream in current/last burst.

## Operation
- FSM states: IDLE, ISSUE, GAP, FIN.
- IDLE
  - On `Start`=1: latch `Burst_len` into `len_q`, clear `issued` and `Word_cnt`, go to ISSUE.
  - `Start` in any other state is ignored.
- ISSUE: `Rden` = !`Empty` && (`skid_cnt` < 2) && (`len_q`==0 || `issued` < `len_q`) && `issued` != 2^BURST_W−1.
  - If `Rden`=1: `issued`+1, go to GAP.
  - Else, if no further read is allowed and `skid_cnt`==0: go to FIN. No further read is allowed when:
    - fixed mode: `issued`==`len_q`;
    - drain mode: `Empty`=1, or `issued` reached 2^BURST_W−1.
  - Else stay in ISSUE. In fixed mode an `Empty` stall waits indefinitely.
- GAP: `Rden`=0. Push `Dataout` into the skid buffer, then go to ISSUE. The mandatory idle cycle lets the lagging `Empty` reflect the previous read before the next issue decision.
- FIN: assert `Done` for one cycle, go to IDLE.
- Skid buffer: 2-entry FIFO; `Out_data` = head, `Out_valid` = (`skid_cnt` != 0).
  - Simultaneous push and pop keeps `skid_cnt` unchanged; order is preserved.
  - The issue rule guarantees no overflow.
- `Word_cnt` increments on every `Out_valid` && `Out_ready`. It holds after `Done` until the next accepted `Start`.
- Data value 0 is a legal word. Validity comes only from the GAP timing, never from `Dataout` contents.
- Fixed mode with `Burst_len`=1..N: exactly `Burst_len` `Rden` pulses, exactly `Burst_len` downstream transfers.
- Drain mode on an already-empty buffer: no `Rden`, `Done` after 2 cycles, `Word_cnt`=0.

## Timing
- Reset (`Rst`=0, asynchronous) forces:
  - state IDLE;
  - `Rden`=0, `Out_valid`=0, `Out_data`=0, `Busy`=0, `Done`=0, `Word_cnt`=0;
  - skid buffer emptied, `issued`=0.
- Reset mid-burst discards captured words. No `Rden` is issued until the next `Start`.
- `Rden` is combinational from registered state, `Empty`, and the counters. All other outputs are registered.
- `Start` sampled at edge E0:
  - ISSUE in cycle 1, and `Rden` in cycle 1 if `Empty`=0;
  - `Dataout` captured at edge E2;
  - `Out_valid`=1 in cycle 2 + 1 = cycle 3 (from `Start` edge: 3 cycles).
- Maximum read rate is 1 `Rden` per 2 cycles; consecutive-cycle `Rden` never occurs.
- Downstream stall: at most 2 words buffered. `Rden` stops while `skid_cnt`==2 and resumes the first ISSUE cycle after a pop.
- `Done` occurs at least 1 cycle after the final downstream transfer (FIN is entered only with the skid empty).

## Test plan
- Buffer preloaded with 5 words (0x11..0x15), `Burst_len`=3, `Out_ready`=1:
  - 3 `Rden` pulses spaced 2 cycles apart;
  - `Out_data` 0x11, 0x12, 0x13;
  - `Word_cnt`=3, one `Done` pulse;
  - buffer retains 2 words.
- Buffer preloaded with 4 words, `Burst_len`=0 (drain): 4 transfers in order, then `Done`; `Word_cnt`=4; no `Rden` once `Empty`=1.
- `Out_ready`=0 for 10 cycles during a 6-word burst:
  - `Rden` stops after 2 captures;
  - no word lost or duplicated; order preserved after `Out_ready`=1.
- Fixed burst of 4 with only 2 words present: FSM waits in ISSUE. Writing 2 more words completes the burst with `Done`; `Word_cnt`=4.
- Buffer containing data words 0x0 and 0xFFFFFFFF: both delivered as valid words.
- `Rst`=0 asserted mid-burst with 1 word in skid:
  - all outputs reset immediately;
  - a second `Start` begins a clean burst with `Word_cnt` starting at 0;
  - `Start` pulsed while `Busy`=1 has no effect.

Source files
------------

// File: rtl/buffer_reader.sv
// Read-side controller for the FIFO/LIFO buffer: issues Rden against Empty,
// captures returned words into a 2-entry skid buffer and streams them out.
module buffer_reader #(
  parameter int dat_width = 32,
  parameter int BURST_W   = 8
) (
  input  logic                 Rdclk,
  input  logic                 Rst,
  input  logic                 Empty,
  input  logic [dat_width-1:0] Dataout,
  output logic                 Rden,
  input  logic                 Start,
  input  logic [BURST_W-1:0]   Burst_len,
  output logic [dat_width-1:0] Out_data,
  output logic                 Out_valid,
  input  logic                 Out_ready,
  output logic                 Busy,
  output logic                 Done,
  output logic [BURST_W-1:0]   Word_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, FIN} state_e;

  localparam logic [BURST_W-1:0] CNT_MAX = '1;
  localparam logic [BURST_W-1:0] CNT_ONE = BURST_W'(1);

  state_e               state_q, state_d;
  logic [BURST_W-1:0]   len_q, len_d;
  logic [BURST_W-1:0]   issued_q, issued_d;
  logic [BURST_W-1:0]   word_cnt_q, word_cnt_d;
  logic [dat_width-1:0] skid0_q, skid0_d;
  logic [dat_width-1:0] skid1_q, skid1_d;
  logic [1:0]           skid_cnt_q, skid_cnt_d;

  logic drain_mode;
  logic read_ok;
  logic no_more;
  logic push;
  logic pop;

  // Issue decision and FSM next state.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    word_cnt_d = word_cnt_q;
    Rden       = 1'b0;

    drain_mode = (len_q == '0);
    read_ok    = (skid_cnt_q < 2'd2) && (drain_mode || (issued_q < len_q)) &&
                 (issued_q != CNT_MAX);
    no_more    = drain_mode ? (Empty || (issued_q == CNT_MAX)) : (issued_q == len_q);
    push       = (state_q == GAP);
    pop        = (skid_cnt_q != 2'd0) && Out_ready;

    if (pop) word_cnt_d = word_cnt_q + CNT_ONE;

    case (state_q)
      IDLE: begin
        if (Start) begin
          len_d      = Burst_len;
          issued_d   = '0;
          word_cnt_d = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!Empty && read_ok) begin
          Rden     = 1'b1;
          issued_d = issued_q + CNT_ONE;
          state_d  = GAP;
        end else if (no_more && (skid_cnt_q == 2'd0)) begin
          state_d = FIN;
        end
      end
      // The idle cycle lets the lagging Empty catch up with the last read.
      GAP:     state_d = ISSUE;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Skid buffer: skid0 is always the head; a pop shifts skid1 forward.
  always_comb begin
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    case ({push, pop})
      2'b10: begin
        if (skid_cnt_q == 2'd0) skid0_d = Dataout;
        else                    skid1_d = Dataout;
        skid_cnt_d = skid_cnt_q + 2'd1;
      end
      2'b01: begin
        skid0_d    = skid1_q;
        skid_cnt_d = skid_cnt_q - 2'd1;
      end
      2'b11: begin
        if (skid_cnt_q == 2'd1) begin
          skid0_d = Dataout;
        end else begin
          skid0_d = skid1_q;
          skid1_d = Dataout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Rdclk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      word_cnt_q <= '0;
      // NOTE: the skid storage is reset too, because Out_data must read zero after reset.
      skid0_q    <= '0;
      skid1_q    <= '0;
      skid_cnt_q <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      word_cnt_q <= word_cnt_d;
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
      skid_cnt_q <= skid_cnt_d;
    end
  end

  assign Out_data  = skid0_q;
  assign Out_valid = (skid_cnt_q != 2'd0);
  assign Busy      = (state_q != IDLE);
  assign Done      = (state_q == FIN);
  assign Word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_buffer_reader.sv
// Self-checking bench for buffer_reader: behavioural buffer with lagging Empty,
// in-order scoreboard of written words, table-driven and random bursts.
module tb_buffer_reader;

  logic        clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Empty = 1'b1;
  logic [31:0] Dataout = '0;
  logic        Rden;
  logic        Start = 1'b0;
  logic [7:0]  Burst_len = '0;
  logic [31:0] Out_data;
  logic        Out_valid;
  logic        Out_ready = 1'b1;
  logic        Busy;
  logic        Done;
  logic [7:0]  Word_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] buf_q[$];
  logic [31:0] exp_q[$];
  logic        rden_prev = 1'b0;

  buffer_reader #(.dat_width(32), .BURST_W(8)) dut (
    .Rdclk(clk), .Rst(Rst), .Empty(Empty), .Dataout(Dataout), .Rden(Rden),
    .Start(Start), .Burst_len(Burst_len), .Out_data(Out_data),
    .Out_valid(Out_valid), .Out_ready(Out_ready), .Busy(Busy), .Done(Done),
    .Word_cnt(Word_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Buffer model: registered read data, Empty lags the contents by one edge.
  always @(posedge clk) begin
    Empty <= (buf_q.size() == 0);
    if (Rden && buf_q.size() != 0) Dataout <= buf_q.pop_front();
    else                           Dataout <= '0;
  end

  // Stream scoreboard and read-strobe legality, sampled mid-cycle.
  always @(negedge clk) begin
    if (Rst) begin
      if (Out_valid && Out_ready) begin
        if (exp_q.size() == 0) check("xfer_unexpected", 1, 0);
        else                   check("xfer_data", Out_data, exp_q.pop_front());
      end
      if (Rden) check("rden_legal", {rden_prev, buf_q.size() == 0, !Busy}, 3'b000);
      rden_prev = Rden;
    end else begin
      rden_prev = 1'b0;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    buf_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic clear_and_settle();
    buf_q.delete();
    exp_q.delete();
    cycle();
    cycle();
  endtask

  task automatic start_burst(input logic [7:0] len);
    cycle();
    Start     = 1'b1;
    Burst_len = len;
  endtask

  task automatic wait_done(input int budget, input bit rnd, input int poke,
                           output int n_rden, output int n_cyc);
    bit seen;
    seen   = 1'b0;
    n_rden = 0;
    n_cyc  = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      cycle();
      Start = (c == poke);
      if (c == poke) Burst_len = 8'd1;
      Out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (Rden) n_rden++;
      if (Done) begin
        seen  = 1'b1;
        n_cyc = c + 1;
      end
    end
    check("done_seen", seen, 1);
    cycle();
    Start     = 1'b0;
    Out_ready = 1'b1;
    @(negedge clk);
    check("idle_after_done", {Busy, Done}, 2'b00);
  endtask

  typedef struct {
    int         n_words;
    logic [7:0] len;
    int         exp_xfers;
    int         exp_left;
    bit         rnd_ready;
    int         exp_cyc;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   nr, nc, n, cnt;

    vecs[0] = '{5, 8'd3, 3, 2, 1'b0, 9};
    vecs[1] = '{4, 8'd0, 4, 0, 1'b0, -1};
    vecs[2] = '{1, 8'd1, 1, 0, 1'b0, -1};
    vecs[3] = '{3, 8'd3, 3, 0, 1'b1, -1};
    vecs[4] = '{6, 8'd2, 2, 4, 1'b1, -1};
    vecs[5] = '{0, 8'd0, 0, 0, 1'b0, 2};

    // Reset state
    cycle();
    cycle();
    check("reset_outputs", {Rden, Out_valid, Out_data, Busy, Done, Word_cnt}, '0);
    Rst = 1'b1;

    // Table-driven bursts
    foreach (vecs[i]) begin
      clear_and_settle();
      for (int k = 0; k < vecs[i].n_words; k++)
        push_word(i == 0 ? 32'h11 + 32'(k) : $urandom);
      cycle();
      cycle();
      start_burst(vecs[i].len);
      wait_done(400, vecs[i].rnd_ready, -1, nr, nc);
      check("tbl_rden_count", nr, vecs[i].exp_xfers);
      check("tbl_word_cnt", Word_cnt, vecs[i].exp_xfers);
      check("tbl_buf_left", buf_q.size(), vecs[i].exp_left);
      check("tbl_all_delivered", exp_q.size(), vecs[i].exp_left);
      if (vecs[i].exp_cyc >= 0) check("tbl_done_cycle", nc, vecs[i].exp_cyc);
    end

    // Random bursts against the reference: fixed mode delivers len words, drain delivers all
    for (int it = 0; it < 10; it++) begin
      int   nw, ex;
      logic [7:0] ln;
      clear_and_settle();
      nw = $urandom_range(0, 7);
      ln = 8'($urandom_range(0, nw));
      ex = (ln == 0) ? nw : int'(ln);
      for (int k = 0; k < nw; k++) push_word($urandom);
      cycle();
      cycle();
      start_burst(ln);
      wait_done(400, 1'b1, -1, nr, nc);
      check("rnd_rden_count", nr, ex);
      check("rnd_word_cnt", Word_cnt, ex);
      check("rnd_buf_left", buf_q.size(), nw - ex);
    end

    // Start-to-valid latency with the all-zero and all-ones words
    clear_and_settle();
    push_word(32'h0);
    push_word(32'hFFFF_FFFF);
    cycle();
    cycle();
    start_burst(8'd0);
    cycle();
    Start = 1'b0;
    @(negedge clk);
    check("lat_c1_busy_rden", {Busy, Rden}, 2'b11);
    cycle();
    @(negedge clk);
    check("lat_c2_rden_valid", {Rden, Out_valid}, 2'b00);
    cycle();
    @(negedge clk);
    check("lat_c3_valid", Out_valid, 1);
    check("lat_c3_zero_word", Out_data, 32'h0);
    wait_done(100, 1'b0, -1, nr, nc);
    check("lat_word_cnt", Word_cnt, 2);
    check("lat_all_delivered", exp_q.size(), 0);

    // Downstream stall during a 6-word burst
    clear_and_settle();
    for (int k = 0; k < 6; k++) push_word(32'hA0 + 32'(k));
    cycle();
    cycle();
    Out_ready = 1'b0;
    start_burst(8'd6);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      Start = 1'b0;
      @(negedge clk);
      if (Rden) cnt++;
    end
    check("stall_rden_count", cnt, 2);
    check("stall_valid_held", {Out_valid, Word_cnt}, {1'b1, 8'd0});
    wait_done(200, 1'b0, -1, nr, nc);
    check("stall_rest_rden", nr, 4);
    check("stall_word_cnt", Word_cnt, 6);
    check("stall_all_delivered", exp_q.size(), 0);

    // Fixed burst of 4 with only 2 words present, then the rest arrives
    clear_and_settle();
    push_word(32'h51);
    push_word(32'h52);
    cycle();
    cycle();
    start_burst(8'd4);
    cnt = 0;
    n   = 0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      Start = 1'b0;
      @(negedge clk);
      if (Rden) cnt++;
      if (Done) n++;
    end
    check("wait_rden_count", cnt, 2);
    check("wait_busy_no_done", {Busy, 8'(n)}, {1'b1, 8'd0});
    cycle();
    push_word(32'h53);
    push_word(32'h54);
    @(negedge clk);
    cnt = Rden ? 1 : 0;
    wait_done(200, 1'b0, -1, nr, nc);
    check("wait_rest_rden", nr + cnt, 2);
    check("wait_word_cnt", Word_cnt, 4);

    // Reset mid-burst with one word in the skid buffer
    clear_and_settle();
    for (int k = 0; k < 4; k++) push_word(32'hC0 + 32'(k));
    cycle();
    cycle();
    Out_ready = 1'b0;
    start_burst(8'd4);
    cycle();
    Start = 1'b0;
    cycle();
    cycle();
    check("rst_skid_loaded", Out_valid, 1);
    Rst = 1'b0;
    #1;
    check("rst_async_outputs", {Rden, Out_valid, Out_data, Busy, Done, Word_cnt}, '0);
    void'(exp_q.pop_front());
    cycle();
    cycle();
    Rst = 1'b1;
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      @(negedge clk);
      if (Rden || Busy) cnt++;
    end
    check("rst_no_rden_idle", cnt, 0);
    Out_ready = 1'b1;
    start_burst(8'd3);
    wait_done(200, 1'b0, 4, nr, nc);
    check("rst_burst_rden", nr, 3);
    check("rst_burst_word_cnt", Word_cnt, 3);
    check("rst_all_delivered", exp_q.size(), 0);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      @(negedge clk);
      if (Rden || Busy) cnt++;
    end
    check("busy_start_ignored", cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
